// File: rtl/alu_share_arbiter_if.sv
// Bundle of the two requester ports, the shared response bus and the external ALU drive.
// The arbiter connects through "slave"; requesters plus the ALU model connect through "master".
interface alu_share_arbiter_if #(
   parameter int unsigned WIDTH   = 64,
   parameter int unsigned CNTRL_W = 3
);
   localparam int unsigned FLAG_W = 4;

   // requester 0 (fetch / branch-target unit)
   logic               req0_valid;
   logic               req0_ready;
   logic [WIDTH-1:0]   req0_A;
   logic [WIDTH-1:0]   req0_B;
   logic [CNTRL_W-1:0] req0_cntrl;

   // requester 1 (execute stage)
   logic               req1_valid;
   logic               req1_ready;
   logic [WIDTH-1:0]   req1_A;
   logic [WIDTH-1:0]   req1_B;
   logic [CNTRL_W-1:0] req1_cntrl;

   // shared response bus, qualified per owner
   logic               resp0_valid;
   logic               resp0_ready;
   logic               resp1_valid;
   logic               resp1_ready;
   logic [WIDTH-1:0]   resp_result;
   logic [FLAG_W-1:0]  resp_flags;

   // external combinational ALU
   logic [WIDTH-1:0]   alu_A;
   logic [WIDTH-1:0]   alu_B;
   logic [CNTRL_W-1:0] alu_cntrl;
   logic [WIDTH-1:0]   alu_result;
   logic [FLAG_W-1:0]  alu_flags;

   modport slave (
      input  req0_valid, req0_A, req0_B, req0_cntrl,
      output req0_ready,
      input  req1_valid, req1_A, req1_B, req1_cntrl,
      output req1_ready,
      output resp0_valid, resp1_valid, resp_result, resp_flags,
      input  resp0_ready, resp1_ready,
      output alu_A, alu_B, alu_cntrl,
      input  alu_result, alu_flags
   );

   modport master (
      output req0_valid, req0_A, req0_B, req0_cntrl,
      input  req0_ready,
      output req1_valid, req1_A, req1_B, req1_cntrl,
      input  req1_ready,
      input  resp0_valid, resp1_valid, resp_result, resp_flags,
      output resp0_ready, resp1_ready,
      input  alu_A, alu_B, alu_cntrl,
      output alu_result, alu_flags
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU between two requesters.
// One operation in flight at a time: accept (IDLE) -> compute (EXEC) -> hold result (RESP).
module alu_share_arbiter #(
   parameter int unsigned WIDTH   = 64,
   parameter int unsigned CNTRL_W = 3
) (
   input  logic               clk,
   input  logic               reset,
   alu_share_arbiter_if.slave bus,
   output logic               busy
);
   localparam int unsigned FLAG_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [WIDTH-1:0]   a;
      logic [WIDTH-1:0]   b;
      logic [CNTRL_W-1:0] cntrl;
   } op_t;

   state_t            state;
   state_t            state_nxt;
   op_t               op_q;
   op_t               op_in_c;
   logic              last_grant;
   logic              owner;
   logic [WIDTH-1:0]  result_q;
   logic [FLAG_W-1:0] flags_q;
   logic              grant0_c;
   logic              grant1_c;
   logic              accept_c;
   logic              resp_done_c;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Grant, handshake detection and next state
   always_comb begin
      state_nxt   = state;
      grant0_c    = 1'b0;
      grant1_c    = 1'b0;
      accept_c    = 1'b0;
      resp_done_c = 1'b0;
      op_in_c     = op_q;

      unique case (state)
         IDLE: begin
            // Tie goes to the port that did not win last time
            if (bus.req0_valid && bus.req1_valid) begin
               grant0_c = last_grant;
               grant1_c = ~last_grant;
            end else begin
               grant0_c = bus.req0_valid;
               grant1_c = bus.req1_valid;
            end
            accept_c = grant0_c | grant1_c;
            if (grant1_c) begin
               op_in_c = '{a: bus.req1_A, b: bus.req1_B, cntrl: bus.req1_cntrl};
            end else begin
               op_in_c = '{a: bus.req0_A, b: bus.req0_B, cntrl: bus.req0_cntrl};
            end
            if (accept_c) begin
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            state_nxt = RESP;
         end
         RESP: begin
            resp_done_c = owner ? bus.resp1_ready : bus.resp0_ready;
            if (resp_done_c) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand, ownership and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q       <= '0;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         result_q   <= '0;
         flags_q    <= '0;
      end else begin
         if (accept_c) begin
            op_q       <= op_in_c;
            owner      <= grant1_c;
            last_grant <= grant1_c;
         end
         if (state == EXEC) begin
            result_q <= bus.alu_result;
            flags_q  <= bus.alu_flags;
         end
      end
   end

   // ALU operands always come from the operand register, so they never glitch between ops
   assign bus.alu_A       = op_q.a;
   assign bus.alu_B       = op_q.b;
   assign bus.alu_cntrl   = op_q.cntrl;

   assign bus.req0_ready  = grant0_c;
   assign bus.req1_ready  = grant1_c;
   assign bus.resp0_valid = (state == RESP) && !owner;
   assign bus.resp1_valid = (state == RESP) && owner;
   assign bus.resp_result = result_q;
   assign bus.resp_flags  = flags_q;
   assign busy            = (state != IDLE);

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one combinational 64-bit ALU between two requesters (fetch/branch-target unit = port 0, execute stage = port 1). Round-robin arbitration, valid/ready request and response handshakes, and registered operands and results. The ALU sits outside this block: the arbiter drives its operands and control code and samples its result and flags.

Parameters:
WIDTH, 64, operand/result width in bits
CNTRL_W, 3, ALU control code width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  arbiter accepts requester 0 this cycle
req0_A, req0_B  in  WIDTH  requester 0 operands
req0_cntrl  in  CNTRL_W  requester 0 ALU op code
req1_valid / req1_ready / req1_A / req1_B / req1_cntrl  as above, requester 1
resp0_valid  out  1  result for requester 0 is held on resp_*
resp0_ready  in  1  requester 0 consumes the result
resp1_valid / resp1_ready  as above, requester 1
resp_result  out  WIDTH  registered ALU result
resp_flags  out  4  registered {negative, zero, overflow, carry_out}
alu_A, alu_B  out  WIDTH  ALU operand drive
alu_cntrl  out  CNTRL_W  ALU op drive
alu_result  in  WIDTH  ALU result
alu_flags  in  4  ALU {negative, zero, overflow, carry_out}
busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset: state=IDLE, last_grant=1 (so requester 0 wins the first tie), operand/op regs=0, resp_result=0, resp_flags=0, owner=0. All valid/ready outputs and busy are 0.
- IDLE:
  - Grant is combinational. If exactly one reqN_valid is high, that port wins. If both are high, the port not equal to last_grant wins.
  - reqN_ready=1 only for the winning port. Both readies are 0 in every other state.
  - On a handshake (valid&&ready): latch A, B and cntrl into operand regs, set owner=N, set last_grant=N, go to EXEC.
- EXEC:
  - alu_A/alu_B/alu_cntrl come from the operand regs. The ALU gets a full clock period.
  - At the clock edge: capture alu_result and alu_flags into resp_result and resp_flags, go to RESP.
- RESP:
  - resp<owner>_valid=1; the other resp valid is 0.
  - The held result and flags stay stable until resp<owner>_ready=1. That handshake returns the FSM to IDLE.
  - Back-to-back: a new request is not accepted in the same cycle as the response handshake. Minimum is 3 cycles per op.
- ALU drive outside EXEC/RESP: alu_A, alu_B and alu_cntrl hold the last operand register values. No glitching to unknowns.
- Latency: a request accepted at edge T gives resp_valid from cycle T+2 onward.
- Invalid/unused cntrl codes pass through unchanged; the ALU defines the result.
- reqN_valid changes while not ready are ignored. Requesters must hold valid and operands until ready.
- Fairness: under continuous requests from both ports, grants strictly alternate 0,1,0,1...
- Reset mid-operation (EXEC or RESP): the op is dropped, no response is issued, state returns to IDLE, last_grant=1.
- respN_ready asserted while respN_valid=0 has no effect.

Test Plan:
1. Reset, then req0 with A=5, B=3, cntrl=ADD, resp0_ready=1 -> req0_ready=1 at cycle 0, resp0_valid=1 at cycle 2, resp_result=8, flags=0000, busy falls at cycle 3.
2. Both ports valid continuously with distinct ops, resp readies tied 1 -> grant order 0,1,0,1; each response appears on the correct respN_valid; one op per 3 cycles.
3. req1 SUB with A=0, B=1 -> resp_result=all ones, negative=1, carry_out=0; resp1_ready held low 4 cycles -> result, flags and resp1_valid stay stable; req0_ready stays 0 throughout.
4. ADD with A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> overflow=1, negative=1. ADD with A=all ones, B=1 -> result=0, zero=1, carry_out=1.
5. Assert reset during EXEC, then during RESP -> no resp valid appears, busy=0 next cycle, and the next simultaneous request is granted to port 0.
6. req0_valid toggling while req1 is in flight -> req0 accepted only after the req1 response handshake, with operands sampled at its own handshake cycle.
